// File: rtl/pacman_pkg.sv
// Shared Pac-Man types and constants: facing direction, visible-area bounds,
// and the stateless body/mouth pixel test.
package pacman_pkg;

    typedef enum logic [1:0] {
        DIR_R = 2'd0,
        DIR_L = 2'd1,
        DIR_U = 2'd2,
        DIR_D = 2'd3
    } dir_t;

    localparam int H_BRIGHT_MIN = 144;
    localparam int H_BRIGHT_MAX = 783;
    localparam int V_BRIGHT_MIN = 35;
    localparam int V_BRIGHT_MAX = 515;
    localparam int SPRITE_SIZE  = 16;

    // Top-left limits that keep the whole 16x16 sprite inside the visible area
    localparam int X_MIN = H_BRIGHT_MIN;
    localparam int X_MAX = H_BRIGHT_MAX - SPRITE_SIZE + 1;
    localparam int Y_MIN = V_BRIGHT_MIN;
    localparam int Y_MAX = V_BRIGHT_MAX - SPRITE_SIZE + 1;

    // Doubled coordinates centre the disc at 7.5 so it stays symmetric on the 16x16 grid
    function automatic logic spritePixel(input logic [3:0] lx, input logic [3:0] ly,
                                         input dir_t d, input logic mouthOpen);
        logic signed [5:0] dx;
        logic signed [5:0] dy;
        logic [4:0]        ax;
        logic [4:0]        ay;
        logic [9:0]        r2;
        logic              wedge;
        dx = $signed({1'b0, lx, 1'b0}) - 6'sd15;
        dy = $signed({1'b0, ly, 1'b0}) - 6'sd15;
        ax = dx[5] ? 5'(-dx) : 5'(dx);
        ay = dy[5] ? 5'(-dy) : 5'(dy);
        r2 = 10'(ax) * 10'(ax) + 10'(ay) * 10'(ay);
        case (d)
            DIR_R:   wedge = (lx >= 4'd8) && (ay <= ax);
            DIR_L:   wedge = (lx <= 4'd7) && (ay <= ax);
            DIR_U:   wedge = (ly <= 4'd7) && (ax <= ay);
            default: wedge = (ly >= 4'd8) && (ax <= ay);
        endcase
        return (r2 <= 10'd256) && !(mouthOpen && wedge);
    endfunction

endpackage

// File: rtl/frame_tick.sv
// Produces a single-clock pulse when the scan position first arrives at {0,0}.
module frame_tick (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [9:0] hCount,
    input  logic [9:0] vCount,
    output logic       tick
);

    logic [19:0] prevScan;

    // Reset to {0,0} so a scan that is already at the origin does not fire
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            prevScan <= '0;
        end else begin
            prevScan <= {hCount, vCount};
        end
    end

    assign tick = ({hCount, vCount} == 20'd0) && (prevScan != 20'd0);

endmodule

// File: rtl/pacman_sprite.sv
// Pac-Man sprite: queued-direction movement inside the visible box, mouth
// animation and the per-pixel fill signal for the display path.
module pacman_sprite
    import pacman_pkg::*;
#(
    parameter int STEP      = 2,
    parameter int FRAME_DIV = 1,
    parameter int START_X   = 456,
    parameter int START_Y   = 267
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [9:0] hCount,
    input  logic [9:0] vCount,
    input  logic       btnU,
    input  logic       btnD,
    input  logic       btnL,
    input  logic       btnR,
    input  logic       freeze,
    output logic       pacmanFill,
    output logic [9:0] pacX,
    output logic [9:0] pacY,
    output logic [1:0] dir,
    output logic       moving
);

    localparam logic signed [10:0] STEP_S  = 11'(STEP);
    localparam logic signed [10:0] X_MIN_S = 11'(X_MIN);
    localparam logic signed [10:0] X_MAX_S = 11'(X_MAX);
    localparam logic signed [10:0] Y_MIN_S = 11'(Y_MIN);
    localparam logic signed [10:0] Y_MAX_S = 11'(Y_MAX);
    localparam logic [3:0]         LAST_FRAME = 4'(FRAME_DIV - 1);

    dir_t               dirReg;
    dir_t               qdir;
    dir_t               nextDir;
    logic               frameTick;
    logic               moveTick;
    logic               nextMoving;
    logic [3:0]         frameCnt;
    logic [2:0]         animCnt;
    logic signed [10:0] qx, qy, cx, cy, nextX, nextY;
    logic [10:0]        relX, relY;

    frame_tick uFrameTick (
        .clk    (clk),
        .rst_n  (rst_n),
        .hCount (hCount),
        .vCount (vCount),
        .tick   (frameTick)
    );

    function automatic logic signed [10:0] stepAxis(input logic [9:0] pos,
                                                    input logic plus, input logic minus);
        return $signed({1'b0, pos}) + (plus ? STEP_S : 11'sd0) - (minus ? STEP_S : 11'sd0);
    endfunction

    function automatic logic inBox(input logic signed [10:0] x, input logic signed [10:0] y);
        return (x >= X_MIN_S) && (x <= X_MAX_S) && (y >= Y_MIN_S) && (y <= Y_MAX_S);
    endfunction

    function automatic logic signed [10:0] clampS(input logic signed [10:0] v,
                                                  input logic signed [10:0] lo,
                                                  input logic signed [10:0] hi);
        return (v < lo) ? lo : ((v > hi) ? hi : v);
    endfunction

    assign moveTick = frameTick && !freeze && (frameCnt == LAST_FRAME);

    // Prefer the queued direction, fall back to the current heading, else stop at the wall
    always_comb begin
        qx         = stepAxis(pacX, qdir == DIR_R, qdir == DIR_L);
        qy         = stepAxis(pacY, qdir == DIR_D, qdir == DIR_U);
        cx         = stepAxis(pacX, dirReg == DIR_R, dirReg == DIR_L);
        cy         = stepAxis(pacY, dirReg == DIR_D, dirReg == DIR_U);
        nextDir    = dirReg;
        nextMoving = 1'b1;
        nextX      = cx;
        nextY      = cy;
        if (inBox(qx, qy)) begin
            nextDir = qdir;
            nextX   = qx;
            nextY   = qy;
        end else if (!inBox(cx, cy)) begin
            nextX      = clampS(cx, X_MIN_S, X_MAX_S);
            nextY      = clampS(cy, Y_MIN_S, Y_MAX_S);
            nextMoving = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            qdir <= DIR_R;
        end else if (btnU) begin
            qdir <= DIR_U;
        end else if (btnD) begin
            qdir <= DIR_D;
        end else if (btnL) begin
            qdir <= DIR_L;
        end else if (btnR) begin
            qdir <= DIR_R;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pacX     <= 10'(START_X);
            pacY     <= 10'(START_Y);
            dirReg   <= DIR_R;
            moving   <= 1'b1;
            frameCnt <= 4'd0;
            animCnt  <= 3'd0;
        end else begin
            if (frameTick && !freeze) begin
                frameCnt <= moveTick ? 4'd0 : frameCnt + 4'd1;
                if (moving) begin
                    animCnt <= animCnt + 3'd1;
                end
            end
            if (moveTick) begin
                pacX   <= nextX[9:0];
                pacY   <= nextY[9:0];
                dirReg <= nextDir;
                moving <= nextMoving;
            end
        end
    end

    // Unsigned wrap makes scan positions left of or above the sprite fail the < 16 test
    assign relX       = {1'b0, hCount} - {1'b0, pacX};
    assign relY       = {1'b0, vCount} - {1'b0, pacY};
    assign pacmanFill = (relX < 11'd16) && (relY < 11'd16) &&
                        spritePixel(relX[3:0], relY[3:0], dirReg, animCnt[2]);
    assign dir        = dirReg;

endmodule

// File: tb/tb_pacman_sprite.sv
// Directed bench for pacman_sprite: reset, movement, clamping, pixel shape,
// frame division, freeze and mid-frame reset.
module tb_pacman_sprite;

    logic       clk    = 1'b0;
    logic       rst_n  = 1'b0;
    logic       rst2N  = 1'b0;
    logic [9:0] hCount = 10'd0;
    logic [9:0] vCount = 10'd0;
    logic       btnU = 1'b0, btnD = 1'b0, btnL = 1'b0, btnR = 1'b0, freeze = 1'b0;
    logic       btnU2 = 1'b0, btnD2 = 1'b0, btnL2 = 1'b0, btnR2 = 1'b0, freeze2 = 1'b0;
    logic       pacmanFill, moving, pacmanFill2, moving2;
    logic [9:0] pacX, pacY, pacX2, pacY2;
    logic [1:0] dir, dir2;

    int assertCount = 0;
    int failCount   = 0;
    int tickCount   = 0;
    int t0;
    int upY[4] = '{39, 37, 35, 35};

    pacman_sprite dut (
        .clk(clk), .rst_n(rst_n), .hCount(hCount), .vCount(vCount),
        .btnU(btnU), .btnD(btnD), .btnL(btnL), .btnR(btnR), .freeze(freeze),
        .pacmanFill(pacmanFill), .pacX(pacX), .pacY(pacY), .dir(dir), .moving(moving)
    );

    pacman_sprite #(.FRAME_DIV(3), .START_X(200), .START_Y(100)) dut2 (
        .clk(clk), .rst_n(rst2N), .hCount(hCount), .vCount(vCount),
        .btnU(btnU2), .btnD(btnD2), .btnL(btnL2), .btnR(btnR2), .freeze(freeze2),
        .pacmanFill(pacmanFill2), .pacX(pacX2), .pacY(pacY2), .dir(dir2), .moving(moving2)
    );

    always #5 clk = ~clk;

    // Sample the pulse late in the low phase, before the edge that consumes it
    always begin
        @(negedge clk);
        #4;
        if (dut.frameTick) tickCount++;
    end

    task automatic checkOutput(input string tag, input int observed, input int expected);
        assertCount++;
        assert (observed === expected) else begin
            failCount++;
            $error("[TB] FAIL %s: observed %0d expected %0d", tag, observed, expected);
        end
    endtask

    // One abbreviated frame: two mid-frame scan positions, then the origin
    task automatic applyStimulus(input logic pressUAtTick);
        hCount = 10'd100; vCount = 10'd10;
        repeat (4) @(negedge clk);
        hCount = 10'd799; vCount = 10'd524;
        repeat (4) @(negedge clk);
        hCount = 10'd0; vCount = 10'd0;
        if (pressUAtTick) btnU = 1'b1;
        repeat (4) @(negedge clk);
        btnU = 1'b0;
    endtask

    initial begin
        repeat (3) @(negedge clk);
        checkOutput("resetX", pacX, 456);
        checkOutput("resetY", pacY, 267);
        checkOutput("resetDir", dir, 0);
        checkOutput("resetMoving", moving, 1);
        rst_n = 1'b1;
        repeat (4) @(negedge clk);
        checkOutput("noTickAtFirstOrigin", tickCount, 0);
        checkOutput("noMoveAtFirstOrigin", pacX, 456);

        btnL = 1'b1;
        applyStimulus(1'b0);
        btnL = 1'b0;
        checkOutput("turnLeftDir", dir, 1);
        checkOutput("turnLeftX", pacX, 454);
        btnR = 1'b1; @(negedge clk); btnR = 1'b0;
        applyStimulus(1'b0);
        checkOutput("reverseDir", dir, 0);
        checkOutput("reverseX", pacX, 456);

        for (int i = 0; i < 2; i++) begin
            t0 = tickCount;
            applyStimulus(1'b0);
            checkOutput("ticksPerFrame", tickCount - t0, 1);
            checkOutput("rightX", pacX, 458 + 2 * i);
        end

        applyStimulus(1'b1);
        checkOutput("sameClkOldQdirX", pacX, 462);
        checkOutput("sameClkOldQdirY", pacY, 267);
        applyStimulus(1'b0);
        checkOutput("upAfterLatchY", pacY, 265);
        checkOutput("upAfterLatchDir", dir, 2);

        for (int i = 0; i < 112; i++) applyStimulus(1'b0);
        checkOutput("climbY", pacY, 41);
        for (int i = 0; i < 4; i++) begin
            applyStimulus(1'b0);
            checkOutput("topApproachY", pacY, upY[i]);
        end
        checkOutput("topClampDir", dir, 2);
        checkOutput("topClampMoving", moving, 0);

        btnR = 1'b1; @(negedge clk); btnR = 1'b0;
        applyStimulus(1'b0);
        checkOutput("unclampX", pacX, 464);
        checkOutput("unclampMoving", moving, 1);
        btnU = 1'b1; @(negedge clk); btnU = 1'b0;
        applyStimulus(1'b0);
        checkOutput("continueInDirX", pacX, 466);
        checkOutput("continueInDirDir", dir, 0);

        hCount = 10'd471; vCount = 10'd274;
        #1 checkOutput("fillBeforeReset", pacmanFill, 0);
        @(negedge clk);
        hCount = 10'd400; vCount = 10'd200;
        t0 = tickCount;
        #2 rst_n = 1'b0;
        #1 checkOutput("asyncResetX", pacX, 456);
        checkOutput("asyncResetY", pacY, 267);
        hCount = 10'd471; vCount = 10'd274;
        #1 checkOutput("fillAtResetPos", pacmanFill, 1);
        @(negedge clk);
        hCount = 10'd0; vCount = 10'd0;
        repeat (2) @(negedge clk);
        #2 rst_n = 1'b1;
        repeat (6) @(negedge clk);
        checkOutput("noSpuriousTick", tickCount - t0, 0);
        checkOutput("noSpuriousMove", pacX, 456);
        applyStimulus(1'b0);
        checkOutput("firstFrameAfterReset", pacX, 458);

        #2 rst2N = 1'b1;
        @(negedge clk);
        checkOutput("div3ResetX", pacX2, 200);
        hCount = 10'd215; vCount = 10'd107;
        #1 checkOutput("closedRightEdge", pacmanFill2, 1);
        hCount = 10'd200; vCount = 10'd100;
        #1 checkOutput("closedCorner", pacmanFill2, 0);
        @(negedge clk);

        btnL2 = 1'b1;
        applyStimulus(1'b0);
        applyStimulus(1'b0);
        checkOutput("div3HoldX", pacX2, 200);
        applyStimulus(1'b0);
        btnL2 = 1'b0;
        checkOutput("div3MoveL", pacX2, 198);
        checkOutput("div3DirL", dir2, 1);
        btnR2 = 1'b1; @(negedge clk); btnR2 = 1'b0;
        applyStimulus(1'b0);
        applyStimulus(1'b0);
        checkOutput("div3HoldX2", pacX2, 198);
        applyStimulus(1'b0);
        checkOutput("div3MoveR", pacX2, 200);
        checkOutput("animAfter6", dut2.animCnt, 6);
        hCount = 10'd215; vCount = 10'd107;
        #1 checkOutput("openWedge", pacmanFill2, 0);
        hCount = 10'd207; vCount = 10'd107;
        #1 checkOutput("openBody", pacmanFill2, 1);
        @(negedge clk);
        applyStimulus(1'b0);
        applyStimulus(1'b0);
        checkOutput("div3HoldX3", pacX2, 200);
        applyStimulus(1'b0);
        checkOutput("div3ThirdMove", pacX2, 202);
        checkOutput("animAfter9", dut2.animCnt, 1);

        freeze2 = 1'b1;
        btnU2 = 1'b1; @(negedge clk); btnU2 = 1'b0;
        for (int i = 0; i < 5; i++) applyStimulus(1'b0);
        checkOutput("frozenX", pacX2, 202);
        checkOutput("frozenY", pacY2, 100);
        checkOutput("frozenAnim", dut2.animCnt, 1);
        freeze2 = 1'b0;
        applyStimulus(1'b0);
        applyStimulus(1'b0);
        checkOutput("thawHoldY", pacY2, 100);
        applyStimulus(1'b0);
        checkOutput("thawMoveY", pacY2, 98);
        checkOutput("thawDirU", dir2, 2);

        $display("End of test - %0d assertions evaluated, %0d failures", assertCount, failCount);
        $finish;
    end

endmodule
